// File: rtl/dmem_responder.sv
// Data-memory responder: serves one word load/store per request with a fixed
// multi-cycle latency, stalling the pipeline until the completion pulse.
module dmem_responder #(
  parameter int LATENCY    = 3,
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        stall_o,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [3:0]              cnt_reg, cnt_next;
  logic                    wr_op_reg, wr_op_next;
  logic                    mis_reg, mis_next;
  logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic [31:0]             rdata_reg;
  logic [31:0]             mem [DEPTH];

  logic                    req;
  logic                    mis_in;
  logic [ADDR_WIDTH-1:0]   idx_in;
  logic                    load_fire;
  logic                    store_fire;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_mis;
  logic                    unused_addr_bits;

  assign req    = MemRead_i | MemWrite_i;
  assign idx_in = addr_i[ADDR_WIDTH+1:2];
  assign mis_in = |addr_i[1:0];
  // Upper address bits only select aliases of the same word.
  assign unused_addr_bits = ^addr_i[31:ADDR_WIDTH+2];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_op_next = wr_op_reg;
    mis_next   = mis_reg;
    idx_next   = idx_reg;
    wdata_next = wdata_reg;
    stall_o    = 1'b0;
    valid_o    = 1'b0;
    err_o      = 1'b0;
    load_fire  = 1'b0;
    store_fire = 1'b0;
    rd_idx     = idx_reg;
    rd_mis     = mis_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          stall_o    = 1'b1;
          wr_op_next = MemWrite_i;
          idx_next   = idx_in;
          mis_next   = mis_in;
          wdata_next = data_i;
          cnt_next   = CNT_INIT;
          if (LATENCY > 1) begin
            state_next = BUSY;
          end else begin
            // Single-cycle latency reads straight from the incoming address.
            state_next = DONE;
            load_fire  = ~MemWrite_i;
            rd_idx     = idx_in;
            rd_mis     = mis_in;
          end
        end
      end
      BUSY: begin
        stall_o  = 1'b1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = DONE;
          load_fire  = ~wr_op_reg;
        end
      end
      DONE: begin
        valid_o    = 1'b1;
        err_o      = mis_reg;
        store_fire = wr_op_reg & ~mis_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      wr_op_reg <= 1'b0;
      mis_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_op_reg <= wr_op_next;
      mis_reg   <= mis_next;
      idx_reg   <= idx_next;
      wdata_reg <= wdata_next;
    end
  end

  // Registered read port; a misaligned load returns zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_reg <= 32'h0;
    end else if (load_fire) begin
      rdata_reg <= rd_mis ? 32'h0 : mem[rd_idx];
    end
  end

  // Store commits on the edge leaving DONE so a reset there aborts it.
  always_ff @(posedge clk_i) begin
    if (store_fire && !rst_i) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  assign data_o = rdata_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a cycle-count reference model.
module tb_dmem_responder;

  localparam int MAIN_LAT = 3;

  logic              clk;
  logic              rst;
  logic              rd;
  logic              wr;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [2:0]        stall_v;
  logic [2:0]        valid_v;
  logic [2:0]        err_v;
  logic [2:0][31:0]  data_v;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [13];

  logic [31:0] model_mem [256];
  bit          m_active;
  int          m_done_at;
  bit          m_load;
  bit          m_err;
  logic [31:0] m_val;
  logic [31:0] e_data;
  bit          e_stall, e_valid, e_err;

  dmem_responder #(.LATENCY(MAIN_LAT), .ADDR_WIDTH(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .stall_o(stall_v[0]), .valid_o(valid_v[0]),
    .data_o(data_v[0]), .err_o(err_v[0])
  );

  dmem_responder #(.LATENCY(1), .ADDR_WIDTH(8)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .stall_o(stall_v[1]), .valid_o(valid_v[1]),
    .data_o(data_v[1]), .err_o(err_v[1])
  );

  dmem_responder #(.LATENCY(15), .ADDR_WIDTH(8)) u_lat15 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .stall_o(stall_v[2]), .valid_o(valid_v[2]),
    .data_o(data_v[2]), .err_o(err_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drop();
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
  endtask

  // Holds the request until the completion pulse, as a stalled pipeline would.
  task automatic txn(input int idx, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input bit e_err_i,
                     input bit chk, input logic [31:0] e_data_i);
    int stalls;
    bit got;
    stalls = 0;
    got    = 1'b0;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (valid_v[idx]) begin
        got = 1'b1;
        break;
      end
      if (stall_v[idx]) stalls++;
    end
    check("txn_valid_seen", 32'(got), 32'd1);
    check("txn_stall_cycles", stalls, lat);
    check("txn_stall_in_done", 32'(stall_v[idx]), 32'd0);
    check("txn_err", 32'(err_v[idx]), 32'(e_err_i));
    if (chk) check("txn_data", data_v[idx], e_data_i);
    $display("txn dut=%0d rd=%0d wr=%0d addr=%h wdata=%h stalls=%0d err=%0d data_o=%h",
             idx, r, w, a, d, stalls, err_v[idx], data_v[idx]);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;

    tbl[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1234_5678};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0022, 32'hAAAA_5555, 1'b1, 32'h1234_5678};
    tbl[5]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b0, 32'h1234_5678};
    tbl[6]  = '{1'b1, 1'b0, 32'h0000_0021, 32'h0000_0000, 1'b1, 32'h0000_0000};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_0404, 32'h0BAD_F00D, 1'b0, 32'h0000_0000};
    tbl[8]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
    tbl[9]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0BAD_F00D};
    tbl[10] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0011, 1'b0, 32'hCAFE_F00D};
    tbl[12] = '{1'b1, 1'b0, 32'h0000_0030, 32'h0000_0000, 1'b0, 32'h0000_0011};

    // Reset state of all three latency variants.
    do_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_stall", 32'(stall_v[i]), 32'd0);
      check("reset_valid", 32'(valid_v[i]), 32'd0);
      check("reset_err", 32'(err_v[i]), 32'd0);
      check("reset_data", data_v[i], 32'h0);
    end

    // Latency sweep: load of address 0 straight after reset.
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0, 1, 1'b0, 1'b0, 32'h0);
    do_reset();
    txn(2, 1'b1, 1'b0, 32'h0, 32'h0, 15, 1'b0, 1'b0, 32'h0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      txn(0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, MAIN_LAT,
          tbl[i].exp_err, 1'b1, tbl[i].exp_data);
    end
    drop();

    // Back-to-back loads held continuously: pulse every LATENCY+1 cycles.
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = 32'h10;
    #1;
    for (int c = 0; c < 20; c++) begin
      bit exp_v;
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      exp_v = ((c % (MAIN_LAT + 1)) == MAIN_LAT);
      check("b2b_valid", 32'(valid_v[0]), 32'(exp_v));
      check("b2b_stall", 32'(stall_v[0]), 32'(!exp_v));
      if (exp_v) check("b2b_data", data_v[0], 32'hDEAD_BEEF);
    end
    $display("txn b2b: 20 cycles of held load at 0x10");
    drop();

    // Reset during the second BUSY cycle of a store aborts it.
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 32'h30; wdata = 32'h55;
    #1;
    check("rst_mid_stall_c0", 32'(stall_v[0]), 32'd1);
    @(negedge clk);
    #1;
    check("rst_mid_stall_c1", 32'(stall_v[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_stall_c2", 32'(stall_v[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    #1;
    check("rst_mid_stall_after", 32'(stall_v[0]), 32'd0);
    check("rst_mid_valid_after", 32'(valid_v[0]), 32'd0);
    check("rst_mid_data_after", data_v[0], 32'h0);
    $display("txn reset mid-store to 0x30");
    txn(0, 1'b1, 1'b0, 32'h30, 32'h0, MAIN_LAT, 1'b0, 1'b1, 32'h11);
    drop();

    // Randomized traffic against a cycle-count transaction model.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = $urandom;
      txn(0, 1'b0, 1'b1, 32'(i * 4), model_mem[i], MAIN_LAT, 1'b0, 1'b1, 32'h0);
    end
    m_active = 1'b0;
    m_done_at = 0;
    e_data = 32'h0;
    for (int t = 0; t < 2000; t++) begin
      bit r, w;
      logic [31:0] a, d;
      int widx;
      r = ($urandom_range(0, 9) < 5);
      w = ($urandom_range(0, 9) < 4);
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = $urandom;
      @(negedge clk);
      rd = r; wr = w; addr = a; wdata = d;
      #1;
      if (m_active && t < m_done_at) begin
        e_stall = 1'b1; e_valid = 1'b0; e_err = 1'b0;
      end else if (m_active && t == m_done_at) begin
        e_stall = 1'b0; e_valid = 1'b1; e_err = m_err;
        if (m_load) e_data = m_err ? 32'h0 : m_val;
        m_active = 1'b0;
      end else begin
        e_stall = r | w; e_valid = 1'b0; e_err = 1'b0;
        if (r | w) begin
          m_active  = 1'b1;
          m_done_at = t + MAIN_LAT;
          m_load    = !w;
          m_err     = (a % 4) != 0;
          widx      = int'((a / 4) % 256);
          if (m_load) m_val = model_mem[widx];
          else if (!m_err) model_mem[widx] = d;
        end
      end
      check("rand_ctrl", {29'd0, stall_v[0], valid_v[0], err_v[0]},
            {29'd0, e_stall, e_valid, e_err});
      check("rand_data", data_v[0], e_data);
    end
    drop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the EX/MEM stage's MemRead/MemWrite interface. Serves one word-aligned load or store per request with a fixed multi-cycle latency.
- While a request is outstanding, it drives a stall back to the pipeline. On completion it returns read data for the MEM/WB register to capture.
- Holds the word-addressed memory array internally.

Parameters:
- LATENCY, 3, total stall cycles per request, legal range 1..15.
- ADDR_WIDTH, 8, log2 of word depth; the array holds 2^ADDR_WIDTH 32-bit words.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- MemRead_i  input  1  load request from the EX/MEM register.
- MemWrite_i  input  1  store request from the EX/MEM register.
- addr_i  input  32  byte address, which is the ALU result.
- data_i  input  32  store data, which is RS2 data.
- stall_o  output  1  hold the pipeline while a request is outstanding (combinational).
- valid_o  output  1  one-cycle completion pulse.
- data_o  output  32  load data, registered.
- err_o  output  1  misaligned-access flag, coincident with valid_o.

Behaviour:
- Interface: one clock, clk_i. Synchronous active-high reset, rst_i.
- Reset:
  - On a clock edge with rst_i=1: state=IDLE, counter=0, data_o=0, valid_o=0, err_o=0, latched request cleared.
  - Array contents are not reset.
  - rst_i has priority over every other event.
- State machine states: IDLE, BUSY, DONE.
- IDLE:
  - req = MemRead_i | MemWrite_i.
  - If req: stall_o=1 in this same cycle.
  - Latch op, addr_i, data_i at the edge. Write wins when both MemRead_i and MemWrite_i are 1.
  - Counter loads LATENCY-1.
  - Next state is BUSY if LATENCY>1, otherwise DONE.
  - If no req: stall_o=0 and the state stays IDLE.
- BUSY:
  - stall_o=1.
  - Counter decrements each cycle. When the counter reaches 1, the next state is DONE.
  - Inputs are ignored; the latched values are used.
- DONE:
  - stall_o=0, valid_o=1. The pipeline advances at the end of this cycle.
  - Next state is always IDLE.
  - Inputs present during DONE still show the old request and are NOT accepted.
- Timing: a request first seen in IDLE at cycle T produces stall_o=1 for cycles T..T+LATENCY-1 and valid_o=1 at T+LATENCY. A new request is first accepted at T+LATENCY+1.
- Read:
  - data_o loads mem[index] on the edge entering DONE.
  - data_o holds that value until the next load completes or reset.
  - Stores leave data_o unchanged.
- Write: mem[index] <= latched data on the edge leaving DONE, only when rst_i=0.
- Index: addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so accesses wrap modulo the depth.
- Misaligned (addr[1:0]!=0):
  - The request still takes the full LATENCY.
  - At DONE, err_o=1 and valid_o=1.
  - A misaligned store does not modify the array.
  - A misaligned load sets data_o=0.
- Reset mid-operation (BUSY or DONE): the request is aborted, a pending store is not committed, and stall_o drops the cycle after the reset edge.

Test Plan:
- Store then load (LATENCY=3): MemWrite_i=1, addr_i=0x10, data_i=0xDEADBEEF. Expect stall_o high for 3 cycles, then valid_o=1, err_o=0. Then MemRead_i=1, addr_i=0x10. Expect stall_o 3 cycles, then valid_o=1, data_o=0xDEADBEEF.
- Latency sweep, LATENCY=1 and LATENCY=15, load of addr 0x0 after reset:
  - LATENCY=1: stall_o for exactly 1 cycle, valid_o the next cycle.
  - LATENCY=15: 15 stall cycles.
- Back-to-back: hold MemRead_i=1 continuously. Expect valid_o pulses exactly every LATENCY+1 cycles, and no acceptance in DONE cycles.
- Simultaneous read and write: MemRead_i=1, MemWrite_i=1, addr_i=0x20, data_i=0x12345678. Expect the store performed and data_o unchanged. A subsequent load of 0x20 returns 0x12345678.
- Misaligned and wrap (ADDR_WIDTH=8):
  - Store 0xAAAA5555 to 0x22. Expect err_o=1 with valid_o, and mem[8] unchanged.
  - Store 0x0BADF00D to 0x404. Expect a load of 0x004 to return 0x0BADF00D.
- Reset mid-store: start store 0x55 to 0x30 (prior contents 0x11). Assert rst_i in the second BUSY cycle. Expect stall_o=0 next cycle, data_o=0, and a load of 0x30 returns 0x11.
